// File: rtl/simmem_pkg.sv
// Shared definitions for the simulated memory controller: release-timer
// state encoding plus the bank capacity and burst constants.
package simmem_pkg;

  typedef enum logic [1:0] {
    RelFree    = 2'd0,
    RelCount   = 2'd1,
    RelExpired = 2'd2
  } release_state_e;

  localparam int unsigned WRspBankCapacity  = 16;
  localparam int unsigned RDataBankCapacity = 16;
  localparam int unsigned MaxWBurstLen      = 1;
  localparam int unsigned MaxRBurstLen      = 4;
  localparam int unsigned ReleaseDelayWidth = 8;

  // Width needed to hold a beat count of 1..max_len.
  function automatic int unsigned beat_width(input int unsigned max_len);
    return $clog2(max_len) + 1;
  endfunction

endpackage

// File: rtl/simmem_release_timer.sv
// Per-address release timer: waits out the entry delay, then holds the
// release enable until the programmed number of beats has been released.
module simmem_release_timer
  import simmem_pkg::*;
#(
  parameter int unsigned DelayWidth = 8,
  parameter int unsigned BeatWidth  = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [DelayWidth-1:0] delay_i,
  input  logic [BeatWidth-1:0]  beats_i,
  input  logic                  release_i,
  output logic                  free_o,
  output logic                  expired_o
);

  localparam logic [DelayWidth-1:0] DelayOne = DelayWidth'(1);
  localparam logic [BeatWidth-1:0]  BeatOne  = BeatWidth'(1);

  release_state_e        state;
  logic [DelayWidth-1:0] counter;
  logic [BeatWidth-1:0]  beats;
  logic [BeatWidth-1:0]  load_beats;

  assign load_beats = (beats_i == '0) ? BeatOne : beats_i;

  // The expiry decision looks at the pre-decrement count so that the
  // enable appears exactly D cycles after the handshake (D=0 and D=1
  // both expire on the first following cycle).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= RelFree;
      counter <= '0;
      beats   <= '0;
    end else begin
      unique case (state)
        RelFree: begin
          if (load_i) begin
            beats <= load_beats;
            if (delay_i <= DelayOne) begin
              state   <= RelExpired;
              counter <= '0;
            end else begin
              state   <= RelCount;
              counter <= delay_i - DelayOne;
            end
          end
        end
        RelCount: begin
          counter <= (counter != '0) ? counter - DelayOne : '0;
          if (counter <= DelayOne) begin
            state <= RelExpired;
          end
        end
        RelExpired: begin
          if (release_i) begin
            if (beats <= BeatOne) begin
              state <= RelFree;
              beats <= '0;
            end else begin
              beats <= beats - BeatOne;
            end
          end
        end
        default: begin
          state   <= RelFree;
          counter <= '0;
          beats   <= '0;
        end
      endcase
    end
  end

  assign free_o    = (state == RelFree);
  assign expired_o = (state == RelExpired);

endmodule

// File: rtl/simmem_delay_releaser.sv
// Delay releaser: one release timer per bank address, gating when the
// response bank may emit an entry. Optional SIMMEM_RELEASER_STALL_CNT_EN adds stall_cnt_o.
module simmem_delay_releaser
  import simmem_pkg::*;
#(
  parameter int unsigned Capacity    = 16,
  parameter int unsigned DelayWidth  = 8,
  parameter int unsigned MaxBurstLen = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           entry_valid_i,
  output logic                           entry_ready_o,
  input  logic [$clog2(Capacity)-1:0]    entry_iid_i,
  input  logic [DelayWidth-1:0]          entry_delay_i,
  input  logic [$clog2(MaxBurstLen):0]   entry_burst_len_i,
  output logic [Capacity-1:0]            release_en_o,
  input  logic [Capacity-1:0]            released_addr_onehot_i,
  output logic [Capacity-1:0]            busy_o
`ifdef SIMMEM_RELEASER_STALL_CNT_EN
  ,
  output logic [31:0]                    stall_cnt_o
`endif
);

  localparam int unsigned IidWidth  = $clog2(Capacity);
  localparam int unsigned BeatWidth = $clog2(MaxBurstLen) + 1;

  logic [Capacity-1:0] free;
  logic [Capacity-1:0] expired;
  logic                handshake;

  assign entry_ready_o = free[entry_iid_i];
  assign handshake     = entry_valid_i & entry_ready_o;

  for (genvar i = 0; i < Capacity; i++) begin : g_timer
    logic load;
    assign load = handshake & (entry_iid_i == IidWidth'(i));

    simmem_release_timer #(
      .DelayWidth (DelayWidth),
      .BeatWidth  (BeatWidth)
    ) u_timer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .load_i    (load),
      .delay_i   (entry_delay_i),
      .beats_i   (entry_burst_len_i),
      .release_i (released_addr_onehot_i[i]),
      .free_o    (free[i]),
      .expired_o (expired[i])
    );
  end

  assign release_en_o = expired;
  assign busy_o       = ~free;

`ifdef SIMMEM_RELEASER_STALL_CNT_EN
  // Counts cycles where the bank has something releasable but moved nothing.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if ((|expired) && (released_addr_onehot_i == '0) && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/simmem_delay_releaser.md
SIMMEM_DELAY_RELEASER -- requirements
Module: simmem_delay_releaser

Interface
REQ-001 Parameter Capacity, default 16: number of bank addresses tracked; equals the bank capacity of the response bank being fed.
REQ-002 Parameter DelayWidth, default 8: width of the per-entry delay in cycles.
REQ-003 Parameter MaxBurstLen, default 1: largest burst length accepted; 1 for write responses, MaxRBurstLen for read data.
REQ-004 Port clk_i, input, 1: single clock; all state on rising edge.
REQ-005 Port rst_i, input, 1: asynchronous, active-high reset.
REQ-006 Port entry_valid_i, input, 1: delay calculator presents a new timed entry.
REQ-007 Port entry_ready_o, output, 1: entry accepted this cycle when entry_valid_i is also high.
REQ-008 Port entry_iid_i, input, $clog2(Capacity): bank address (internal identifier) of the entry.
REQ-009 Port entry_delay_i, input, DelayWidth: cycles to wait before release may begin.
REQ-010 Port entry_burst_len_i, input, $clog2(MaxBurstLen)+1: beats to release; 0 treated as 1.
REQ-011 Port release_en_o, output, Capacity: multi-hot release enable per bank address, fed to the bank.
REQ-012 Port released_addr_onehot_i, input, Capacity: one-hot per released beat, from the bank.
REQ-013 Port busy_o, output, Capacity: address is not FREE.

Function
REQ-014 Each address SHALL hold a state FREE, COUNT or EXPIRED, a DelayWidth down-counter and a beat counter.
REQ-015 entry_ready_o SHALL equal (state[entry_iid_i]==FREE), combinational, independent of entry_valid_i.
REQ-016 On handshake with delay D>0: address SHALL go to COUNT with counter=D-1 and beats=max(burst_len,1).
REQ-017 On handshake with D=0: address SHALL go directly to EXPIRED; release_en_o bit rises the next cycle.
REQ-018 In COUNT: counter SHALL decrement by 1 per cycle; at counter==0 the address SHALL move to EXPIRED, so release_en_o rises exactly D cycles after the handshake cycle.
REQ-019 release_en_o[i] SHALL be 1 iff state[i]==EXPIRED; registered, no combinational path from any input.
REQ-020 released_addr_onehot_i[i] high while EXPIRED SHALL decrement beats[i]; at beats 1->0 the address SHALL return to FREE and release_en_o[i] fall the next cycle.
REQ-021 released_addr_onehot_i[i] high while address i is FREE or in COUNT SHALL be ignored.
REQ-022 A handshake and a final release on the same address in the same cycle cannot occur, because ready is low while not FREE; a final release on address i together with a handshake on address j≠i SHALL both take effect.
REQ-023 Multiple addresses SHALL count independently and concurrently; any number may be EXPIRED at once.
REQ-024 Counter arithmetic SHALL NOT wrap: the decrement is gated at 0.

Reset
REQ-025 While rst_i is high, every address SHALL be FREE with counters 0, and outputs SHALL be release_en_o=0, busy_o=0, entry_ready_o=1.
REQ-026 Reset asserted mid-count or mid-burst SHALL discard all entries immediately and asynchronously; no release_en_o pulse SHALL follow deassertion.

Configuration
REQ-027 Macro SIMMEM_RELEASER_STALL_CNT_EN SHALL add output stall_cnt_o, 32 bits, counting cycles in which at least one address is EXPIRED and released_addr_onehot_i is 0; it saturates at all-ones and resets to 0.
REQ-028 Without SIMMEM_RELEASER_STALL_CNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-029 The state enum (FREE/COUNT/EXPIRED) SHALL be defined in simmem_pkg, alongside the existing bank capacity and burst constants.
REQ-030 Per-address logic SHALL be a sub-module simmem_release_timer, instantiated Capacity times by a generate loop.
REQ-031 Two instances SHALL be used: one feeding the write-response bank (MaxBurstLen=1) and one feeding the read-data bank.

Verification
REQ-032 Delay test: handshake iid=3, D=5, len=1 at cycle 0 -> release_en_o[3] rises at cycle 5; released pulse at cycle 7 -> bit falls at cycle 8, busy_o[3]=0.
REQ-033 Zero-delay test: iid=0, D=0 -> release_en_o[0]=1 at cycle 1; entry_ready_o=0 while entry_iid_i=0 until released.
REQ-034 Burst test: iid=2, D=1, len=4, four separate released pulses -> bit stays high after pulses 1-3 and clears only after pulse 4.
REQ-035 Concurrency test: iid=1 with D=10 and iid=4 with D=2 accepted back to back -> bit 4 rises before bit 1; a stray released pulse on bit 1 during COUNT has no effect.
REQ-036 Reset test: rst_i pulsed at cycle 3 of a D=6 count -> release_en_o stays 0 for 20 cycles and entry_ready_o=1.
REQ-037 Macro test, with SIMMEM_RELEASER_STALL_CNT_EN defined: expired address with no release for 7 cycles -> stall_cnt_o=7.
